// File: rtl/up_down_counter.sv
// Modulo up/down counter with a runtime terminal value t; wraps to 0 (up) or reloads t (down).
// Optional terminal-count flag tc is built only when UP_DOWN_CNT_TC_EN is defined.
module up_down_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] t,
   input  logic             mode,
`ifdef UP_DOWN_CNT_TC_EN
   output logic             tc,
`endif
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_nxt;
   logic             at_top;
   logic             at_zero;
   logic             above_t;

   assign at_top  = (count >= t);
   assign at_zero = (count == '0);
   assign above_t = (count > t);

   // A count left above a freshly lowered t wraps (up) or reloads (down) on the next edge.
   always_comb begin
      count_nxt = count;
      if (mode) begin
         if (at_top) count_nxt = '0;
         else        count_nxt = count + WIDTH'(1);
      end else begin
         if (at_zero || above_t) count_nxt = t;
         else                    count_nxt = count - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) count <= '0;
      else      count <= count_nxt;
   end

`ifdef UP_DOWN_CNT_TC_EN
   assign tc = (mode && (count == t)) || (!mode && at_zero);
`endif

endmodule

// File: tb/tb_up_down_counter.sv
// Scoreboard bench for up_down_counter: a driver pushes model predictions, a monitor pops and compares.
module tb_up_down_counter;
   localparam int WIDTH = 3;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] t;
   logic             mode;
   logic [WIDTH-1:0] count;
`ifdef UP_DOWN_CNT_TC_EN
   logic             tc;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int mdl      = 0;
   int exp_q[$];

   up_down_counter #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .t     (t),
      .mode  (mode),
`ifdef UP_DOWN_CNT_TC_EN
      .tc    (tc),
`endif
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: counting modulo (t+1); anything above t is out of range and snaps to the bound.
   function automatic int model_next(int c, int tv, int m);
      if (m != 0) return (c > tv) ? 0  : (c + 1) % (tv + 1);
      else        return (c > tv) ? tv : (c + tv) % (tv + 1);
   endfunction

   task automatic check(string name, int act, int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Called just after a falling edge: apply inputs and predict the value after the next rising edge.
   task automatic drive_cycle(int tv, int m);
      t    = tv[WIDTH-1:0];
      mode = m[0];
      mdl  = model_next(mdl, tv, m);
      exp_q.push_back(mdl);
   endtask

   task automatic step(int tv, int m);
      @(negedge clk);
      drive_cycle(tv, m);
   endtask

   task automatic pulse_reset(int tv, int m);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset", int'(count), 0);
      repeat (2) begin
         @(negedge clk);
         check("reset_hold", int'(count), 0);
      end
      rst = 1'b1;
      mdl = 0;
      drive_cycle(tv, m);
   endtask

   // Monitor: after each rising edge, compare the registered output with the oldest prediction.
   initial begin
      int e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("count", int'(count), e);
`ifdef UP_DOWN_CNT_TC_EN
            check("tc", int'(tc),
                  ((mode && e == int'(t)) || (!mode && e == 0)) ? 1 : 0);
`endif
         end
      end
   end

   initial begin
      int tv;
      int m;
      rst  = 1'b0;
      t    = 3'd7;
      mode = 1'b1;
      #12;
      check("reset_state", int'(count), 0);

      // full-range up count from reset, then 10 edges
      @(negedge clk);
      rst = 1'b1;
      drive_cycle(7, 1);
      repeat (9) step(7, 1);

      // full-range down count from reset
      pulse_reset(7, 0);
      repeat (9) step(7, 0);

      // t=4 up, then t lowered to 2 while count=3
      pulse_reset(4, 1);
      repeat (7) step(4, 1);
      step(2, 1);
      repeat (3) step(2, 1);

      // up to 5, reverse direction, then t=0 in both modes
      pulse_reset(7, 1);
      repeat (4) step(7, 1);
      repeat (4) step(7, 0);
      repeat (3) step(0, 0);
      repeat (3) step(0, 1);

      // lower t in down mode with count above it
      repeat (7) step(7, 1);
      repeat (2) step(3, 0);

      // reset mid-count at 5
      pulse_reset(7, 1);
      repeat (4) step(7, 1);
      pulse_reset(7, 1);

      // randomized traffic with occasional t/mode changes and resets
      tv = 7;
      m  = 1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(7) == 0) tv = $urandom_range(7);
         if ($urandom_range(3) == 0) m  = $urandom_range(1);
         if ($urandom_range(59) == 0) pulse_reset(tv, m);
         else                         step(tv, m);
      end

      begin
         int guard = 0;
         while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
         end
         #2;
         check("drain_timeout", exp_q.size(), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
